uart_opl_write_sequencer: RTL and testbench

//  Sits between the UART receiver and the OPL2 core. Turns the received byte stream into
//  OPL2 register writes: each pair of bytes is (register address, data).

---
 rtl/uart_opl_write_sequencer.sv | 170 +++++++++++++++++
 tb/tb_uart_opl_write_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_opl_write_sequencer.sv
// UART-to-OPL2 write sequencer.
// Pairs received bytes into {address, data} register writes, queues them in a
// small FIFO and issues them to the OPL2 core with a guaranteed minimum spacing
// between write strobes. The receiver idle flag drops a dangling address byte
// so that pairing recovers after a lost or stray byte.
//
//   state | meaning
//   IDLE  | waiting for a queued pair and opl_ready; pops the head pair
//   WRITE | popped pair is on opl_addr/opl_data; strobe fires next cycle
//   GAP   | counting out the remaining spacing before the next pop
module uart_opl_write_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int WRITE_GAP  = 84
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_idle,
  input  logic                          opl_ready,
  output logic                          opl_we,
  output logic [7:0]                    opl_addr,
  output logic [7:0]                    opl_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(WRITE_GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               pop;
  logic               push_ok;
  logic               fifo_full;
  logic               fifo_empty;
  logic               phase;
  logic [7:0]         addr_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   gap_cnt;
  logic [15:0]        mem [FIFO_DEPTH];

  assign fifo_full  = (fifo_level == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  // A pair landing on a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok    = rx_valid & phase & (~fifo_full | pop);
  assign busy       = (state_q != IDLE) | ~fifo_empty;

  // Pair assembler: address latch, phase bit, overflow and frame error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      addr_q    <= 8'h00;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid) begin
        if (!phase) begin
          addr_q <= rx_data;
          phase  <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (fifo_full && !pop) begin
            overflow <= 1'b1;
          end
        end
      end else if (phase && rx_idle) begin
        phase     <= 1'b0;
        frame_err <= 1'b1;
      end
    end
  end

  // FIFO storage; flushing is done through the pointers, so no reset here.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {addr_q, rx_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scheduler next state and pop decision; opl_ready only gates the IDLE exit.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && opl_ready) begin
          pop     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: state_d = GAP;
      // Leaving on the 1->0 step makes the pop-to-pop period exactly WRITE_GAP.
      GAP: begin
        if (gap_cnt <= CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gap counter: loaded only in WRITE, so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state_q == WRITE) begin
      gap_cnt <= CNT_W'(WRITE_GAP - 2);
    end else if (state_q == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Output register: capture the popped pair, strobe one cycle after WRITE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opl_we   <= 1'b0;
      opl_addr <= 8'h00;
      opl_data <= 8'h00;
    end else begin
      opl_we <= (state_q == WRITE);
      if (pop) begin
        opl_addr <= mem[rd_ptr][15:8];
        opl_data <= mem[rd_ptr][7:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_opl_write_sequencer.sv
// Self-checking bench for uart_opl_write_sequencer (FIFO_DEPTH=16, WRITE_GAP=8).
module tb_uart_opl_write_sequencer;
  localparam int FD = 16;
  localparam int WG = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_idle = 1'b0;
  logic       opl_ready = 1'b1;
  logic       opl_we;
  logic [7:0] opl_addr;
  logic [7:0] opl_data;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       frame_err;
  logic       busy;

  uart_opl_write_sequencer #(.FIFO_DEPTH(FD), .WRITE_GAP(WG)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_idle(rx_idle),
    .opl_ready(opl_ready), .opl_we(opl_we), .opl_addr(opl_addr), .opl_data(opl_data),
    .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] w_addr[$];
  logic [7:0] w_data[$];
  int         w_cyc[$];
  int         ov_cnt = 0;
  int         fe_cnt = 0;

  // Monitor: log every write strobe and count the status pulses.
  always @(negedge clk) begin
    if (opl_we) begin
      w_addr.push_back(opl_addr);
      w_data.push_back(opl_data);
      w_cyc.push_back(cyc);
    end
    if (overflow) ov_cnt++;
    if (frame_err) fe_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic clear_log();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
  endtask

  // Present one byte for one clock; e returns the index of the sampling edge.
  task automatic send_byte(input logic [7:0] b, output int e);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    e = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] d, output int e);
    int e0;
    send_byte(a, e0);
    send_byte(d, e);
  endtask

  task automatic wait_idle(input int budget, output int fall);
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        fall = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout after %0d cycles", budget);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] ea;
    logic [7:0] ed;
    int         lat;
    int         busy_lat;
  } vec_t;

  vec_t vt[3];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int fall;
    int ov0;
    int fe0;
    int n;

    vt[0] = '{8'hB0, 8'h32, 8'hB0, 8'h32, 2, 8};
    vt[1] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, 2, 8};
    vt[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 2, 8};

    // Reset state.
    @(negedge clk);
    chk("rst_we", int'(opl_we), 0);
    chk("rst_addr_data", int'({opl_addr, opl_data}), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_flags", int'({overflow, frame_err, busy}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single pairs: content, strobe latency and busy release.
    for (int i = 0; i < 3; i++) begin
      clear_log();
      send_pair(vt[i].a, vt[i].d, e);
      wait_idle(60, fall);
      chk("single_cnt", w_addr.size(), 1);
      if (w_addr.size() > 0) begin
        chk("single_addr", int'(w_addr[0]), int'(vt[i].ea));
        chk("single_data", int'(w_data[0]), int'(vt[i].ed));
        chk("single_lat", w_cyc[0] - e, vt[i].lat);
      end
      chk("busy_fall", fall - e, vt[i].busy_lat);
    end

    // Back-to-back pairs: order and exact spacing.
    clear_log();
    send_pair(8'h20, 8'h01, e);
    send_pair(8'h40, 8'h10, e);
    send_pair(8'h60, 8'hF0, e);
    wait_idle(100, fall);
    chk("b2b_cnt", w_addr.size(), 3);
    if (w_addr.size() == 3) begin
      chk("b2b_pair0", int'({w_addr[0], w_data[0]}), 16'h2001);
      chk("b2b_pair1", int'({w_addr[1], w_data[1]}), 16'h4010);
      chk("b2b_pair2", int'({w_addr[2], w_data[2]}), 16'h60F0);
      chk("b2b_gap01", w_cyc[1] - w_cyc[0], WG);
      chk("b2b_gap12", w_cyc[2] - w_cyc[1], WG);
    end

    // Lone address byte discarded on idle, then pairing resumes.
    clear_log();
    fe0 = fe_cnt;
    send_byte(8'h20, e);
    rx_idle = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    rx_idle = 1'b0;
    chk("fe_pulses", fe_cnt - fe0, 1);
    chk("fe_no_write", w_addr.size(), 0);
    chk("fe_not_busy", int'(busy), 0);
    send_pair(8'h40, 8'h10, e);
    wait_idle(60, fall);
    chk("fe_resync_cnt", w_addr.size(), 1);
    if (w_addr.size() == 1) chk("fe_resync_pair", int'({w_addr[0], w_data[0]}), 16'h4010);

    // Overflow: 17 pairs into a 16-deep FIFO while stalled.
    clear_log();
    opl_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) send_pair(8'(i), 8'(8'h80 + i), e);
    @(negedge clk);
    #1;
    chk("ovf_level", int'(fifo_level), 16);
    chk("ovf_pulses", ov_cnt - ov0, 1);
    chk("ovf_stalled", w_addr.size(), 0);
    opl_ready = 1'b1;
    wait_idle(16 * WG + 40, fall);
    chk("ovf_cnt", w_addr.size(), 16);
    n = (w_addr.size() < 16) ? w_addr.size() : 16;
    for (int i = 0; i < n; i++) begin
      chk("ovf_order", int'({w_addr[i], w_data[i]}), int'({8'(i), 8'(8'h80 + i)}));
    end

    // Full FIFO with the closing byte coinciding with a pop.
    clear_log();
    opl_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) send_pair(8'(8'hC0 + i), 8'(i), e);
    send_byte(8'hEE, e);
    rx_valid  = 1'b1;
    rx_data   = 8'h77;
    opl_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("fullpop_level", int'(fifo_level), 16);
    chk("fullpop_no_ovf", ov_cnt - ov0, 0);
    wait_idle(17 * WG + 40, fall);
    chk("fullpop_cnt", w_addr.size(), 17);
    if (w_addr.size() == 17) begin
      chk("fullpop_first", int'({w_addr[0], w_data[0]}), 16'hC000);
      chk("fullpop_last", int'({w_addr[16], w_data[16]}), 16'hEE77);
    end

    // Reset while in GAP flushes queued pairs.
    clear_log();
    opl_ready = 1'b0;
    send_pair(8'h11, 8'h22, e);
    send_pair(8'h33, 8'h44, e);
    send_pair(8'h55, 8'h66, e);
    opl_ready = 1'b1;
    for (int i = 0; i < 20 && w_addr.size() == 0; i++) @(negedge clk);
    chk("rstgap_first", w_addr.size(), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstgap_level", int'(fifo_level), 0);
    chk("rstgap_outs", int'({opl_we, opl_addr, opl_data, overflow, frame_err, busy}), 0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (3 * WG) @(negedge clk);
    #1;
    chk("rstgap_no_more", w_addr.size(), 1);
    chk("rstgap_idle", int'({busy, fifo_level}), 0);
    send_pair(8'h5A, 8'hA5, e);
    wait_idle(60, fall);
    chk("rstgap_after_cnt", w_addr.size(), 2);
    if (w_addr.size() == 2) chk("rstgap_after_pair", int'({w_addr[1], w_data[1]}), 16'h5AA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
